st_demultiplexer: RTL and testbench

- 1:2 Avalon-ST-style packet demultiplexer; receive-side counterpart of the 2:1 stream multiplexer.
- Takes one stream carrying a channel tag and routes each whole packet (sop..eop) to out0 or out1, selected by in_channel on the sop beat.
- Each output has a registered 2-entry skid buffer, so one stalled output never corrupts or reorders the other.
- Sits between the merged stream and the per-channel consumers.

---
 rtl/st_demultiplexer.sv | 213 +++++++++++++++++++++
 tb/tb_st_demultiplexer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_demultiplexer.sv
// st_demultiplexer: 1:2 packet demultiplexer. Each whole packet (sop..eop) goes to out0 or out1,
//   chosen by in_channel on the sop beat. Each output has a registered 2-entry skid buffer.
// Latency: 1 cycle from input accept to output valid.
// Backpressure: in_ready follows a registered "room" flag of the selected output only. No
//   combinational path from out*_ready to in_ready. Beats outside a packet are always accepted
//   and dropped.
// Ports: clk/reset_n (async active-low); in_* upstream stream with channel tag; out0_*/out1_*
//   per-channel streams; pkt_cnt0/pkt_cnt1/drop_cnt statistics; proto_err sticky framing error.
module st_demultiplexer #(
  parameter int DWIDTH    = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // merged input stream
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic                 in_channel,
  input  logic                 in_sop,
  input  logic                 in_eop,
  // channel 0 output
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [DWIDTH-1:0]    out0_data,
  output logic                 out0_sop,
  output logic                 out0_eop,
  // channel 1 output
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [DWIDTH-1:0]    out1_data,
  output logic                 out1_sop,
  output logic                 out1_eop,
  // statistics
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 proto_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   lat_ch, lat_ch_nxt;

  // Set on the first edge after reset release. It keeps in_ready low during reset,
  // including on the always-accept drop path.
  logic   active;

  // Per-channel skid buffer: a head entry drives the outputs, and a second (skid) entry
  // holds one more beat.
  logic [1:0][DWIDTH-1:0] hd_data, sk_data;
  logic [1:0]             hd_sop, hd_eop, sk_sop, sk_eop;
  logic [1:0][1:0]        cnt, cnt_nxt;
  logic [1:0]             rdy;      // registered: buffer has room after this cycle's updates
  logic [1:0]             push, pop;
  logic [1:0]             out_rdy;

  logic sel;
  logic drop_path;
  logic accept;
  logic fwd_beat;
  logic drop_beat;

  assign out_rdy = {out1_ready, out0_ready};

  // ------------------------------------------------------------------
  // Routing and input handshake
  // ------------------------------------------------------------------
  always_comb begin
    sel       = (state == IDLE || in_sop) ? in_channel : lat_ch;
    // A non-sop beat while idle belongs to no packet. Accept it without
    // looking at buffer room, so a stray beat never stalls the stream.
    drop_path = (state == IDLE) && !in_sop;
    in_ready  = drop_path ? active : rdy[sel];
    accept    = in_valid && in_ready;
    drop_beat = accept && drop_path;
    fwd_beat  = accept && !drop_path;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i]    = fwd_beat && (sel == i[0]);
      pop[i]     = (cnt[i] != 2'd0) && out_rdy[i];
      cnt_nxt[i] = cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
    end
  end

  // ------------------------------------------------------------------
  // Packet framing FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      lat_ch <= 1'b0;
    end else begin
      state  <= state_nxt;
      lat_ch <= lat_ch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lat_ch_nxt = lat_ch;
    case (state)
      IDLE: begin
        if (fwd_beat) begin
          lat_ch_nxt = in_channel;
          state_nxt  = in_eop ? IDLE : IN_PKT;
        end
      end
      IN_PKT: begin
        if (fwd_beat) begin
          // A sop here truncates the open packet and re-latches the channel.
          lat_ch_nxt = sel;
          state_nxt  = in_eop ? IDLE : IN_PKT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Skid buffers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hd_data <= '0;
      sk_data <= '0;
      hd_sop  <= '0;
      hd_eop  <= '0;
      sk_sop  <= '0;
      sk_eop  <= '0;
      cnt     <= '0;
      rdy     <= '0;
      active  <= 1'b0;
    end else begin
      active <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        case ({push[i], pop[i]})
          2'b10: begin
            if (cnt[i] == 2'd0) begin
              hd_data[i] <= in_data;
              hd_sop[i]  <= in_sop;
              hd_eop[i]  <= in_eop;
            end else begin
              sk_data[i] <= in_data;
              sk_sop[i]  <= in_sop;
              sk_eop[i]  <= in_eop;
            end
          end
          2'b01: begin
            // The head leaves. The skid entry, if any, moves up.
            if (cnt[i] == 2'd2) begin
              hd_data[i] <= sk_data[i];
              hd_sop[i]  <= sk_sop[i];
              hd_eop[i]  <= sk_eop[i];
            end
          end
          2'b11: begin
            if (cnt[i] == 2'd1) begin
              hd_data[i] <= in_data;
              hd_sop[i]  <= in_sop;
              hd_eop[i]  <= in_eop;
            end else begin
              hd_data[i] <= sk_data[i];
              hd_sop[i]  <= sk_sop[i];
              hd_eop[i]  <= sk_eop[i];
              sk_data[i] <= in_data;
              sk_sop[i]  <= in_sop;
              sk_eop[i]  <= in_eop;
            end
          end
          default: ;
        endcase
        cnt[i] <= cnt_nxt[i];
        rdy[i] <= (cnt_nxt[i] < 2'd2);
      end
    end
  end

  assign out0_valid = (cnt[0] != 2'd0);
  assign out0_data  = hd_data[0];
  assign out0_sop   = hd_sop[0];
  assign out0_eop   = hd_eop[0];
  assign out1_valid = (cnt[1] != 2'd0);
  assign out1_data  = hd_data[1];
  assign out1_sop   = hd_sop[1];
  assign out1_eop   = hd_eop[1];

  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (fwd_beat && in_eop) begin
        if (sel) pkt_cnt1 <= pkt_cnt1 + 1'b1;
        else     pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end
      if (drop_beat) drop_cnt <= drop_cnt + 1'b1;
      if (drop_beat || (fwd_beat && state == IN_PKT && in_sop)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_demultiplexer.sv
// tb_st_demultiplexer: directed stimulus for st_demultiplexer against a queue-based packet model.
// The model runs on every falling edge and checks handshake, outputs, counters and error flag.
// Hand-computed literal checks pin counter values, latency, stall behaviour and async reset.
module tb_st_demultiplexer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_channel, in_sop, in_eop;
  logic [7:0]  in_data;
  logic        out0_valid, out0_ready, out0_sop, out0_eop;
  logic        out1_valid, out1_ready, out1_sop, out1_eop;
  logic [7:0]  out0_data, out1_data;
  logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;
  logic        proto_err;

  st_demultiplexer #(.DWIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_channel(in_channel), .in_sop(in_sop), .in_eop(in_eop),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out0_sop(out0_sop), .out0_eop(out0_eop),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out1_sop(out1_sop), .out1_eop(out1_eop),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } beat_t;

  beat_t       q0[$], q1[$];      // beats accepted and not yet consumed, per channel
  logic [7:0]  got0[$], got1[$];  // data actually consumed from the DUT, per channel
  logic        m_active = 1'b0;
  logic        m_in_pkt = 1'b0;
  logic        m_ch     = 1'b0;
  logic [15:0] m_pkt0 = '0, m_pkt1 = '0, m_drop = '0;
  logic        m_perr = 1'b0;
  logic        exp_rdy, tgt;
  beat_t       nb;

  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete(); q1.delete();
      m_active = 1'b0; m_in_pkt = 1'b0; m_ch = 1'b0;
      m_pkt0 = '0; m_pkt1 = '0; m_drop = '0; m_perr = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out0_valid", out0_valid, 0);
      chk("rst_out1_valid", out1_valid, 0);
    end else begin
      tgt = (!m_in_pkt || in_sop) ? in_channel : m_ch;
      if (!m_active)                 exp_rdy = 1'b0;
      else if (!m_in_pkt && !in_sop) exp_rdy = 1'b1;
      else                           exp_rdy = ((tgt ? q1.size() : q0.size()) < 2);
      if (in_valid) chk("in_ready", in_ready, exp_rdy);

      chk("out0_valid", out0_valid, q0.size() != 0);
      if (q0.size() != 0) begin
        chk("out0_data", out0_data, q0[0].d);
        chk("out0_sop", out0_sop, q0[0].sop);
        chk("out0_eop", out0_eop, q0[0].eop);
      end
      chk("out1_valid", out1_valid, q1.size() != 0);
      if (q1.size() != 0) begin
        chk("out1_data", out1_data, q1[0].d);
        chk("out1_sop", out1_sop, q1[0].sop);
        chk("out1_eop", out1_eop, q1[0].eop);
      end
      chk("pkt_cnt0", pkt_cnt0, m_pkt0);
      chk("pkt_cnt1", pkt_cnt1, m_pkt1);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("proto_err", proto_err, m_perr);

      // Log what the DUT actually hands to the consumers.
      if (out0_valid && out0_ready) got0.push_back(out0_data);
      if (out1_valid && out1_ready) got1.push_back(out1_data);

      // Apply what the coming rising edge does.
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (!m_in_pkt && !in_sop) begin
          m_drop = m_drop + 1'b1;
          m_perr = 1'b1;
        end else begin
          if (in_sop) begin
            if (m_in_pkt) m_perr = 1'b1;
            m_ch = in_channel;
          end
          nb = '{sop: in_sop, eop: in_eop, d: in_data};
          if (m_ch) q1.push_back(nb); else q0.push_back(nb);
          if (in_eop) begin
            if (m_ch) m_pkt1 = m_pkt1 + 1'b1; else m_pkt0 = m_pkt0 + 1'b1;
            m_in_pkt = 1'b0;
          end else begin
            m_in_pkt = 1'b1;
          end
        end
      end
      m_active = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one beat, hold it until accepted (bounded), and return at rising edge + 1.
  task automatic send(input logic [7:0] d, input logic ch, input logic sop, input logic eop);
    int  n = 0;
    logic acc;
    in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = sop; in_eop = eop;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      mismatched++;
      $display("FAIL send_timeout: beat %0h not accepted, in_ready=%0b, required 1", d, in_ready);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string name, input logic ch, input int n, input logic [31:0] exp);
    int sz = ch ? got1.size() : got0.size();
    chk({name, "_len"}, sz, n);
    for (int i = 0; i < n && i < sz; i++)
      chk(name, ch ? got1[i] : got0[i], exp[8*i +: 8]);
  endtask

  task automatic clear_logs();
    got0.delete();
    got1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_channel = 1'b0;
    in_sop = 1'b0; in_eop = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out0_valid", out0_valid, 0);
    chk("reset_out1_valid", out1_valid, 0);
    chk("reset_pkt_cnt0", pkt_cnt0, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_proto_err", proto_err, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 3-beat packet on ch1, 1-cycle latency.
    send(8'h11, 1'b1, 1'b1, 1'b0);
    chk("t1_lat_valid", out1_valid, 1);
    chk("t1_lat_data", out1_data, 8'h11);
    chk("t1_lat_sop", out1_sop, 1);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0, 1'b1);
    chk("t1_pkt_cnt1", pkt_cnt1, 1);
    chk("t1_out0_idle", out0_valid, 0);
    idle_cycles(3);
    chk_seq("t1_out1_seq", 1'b1, 3, 32'h0033_2211);
    clear_logs();

    // Single-beat ch0 packet followed back-to-back by a 2-beat ch1 packet.
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    send(8'hB1, 1'b1, 1'b1, 1'b0);
    send(8'hB2, 1'b0, 1'b0, 1'b1);
    idle_cycles(3);
    chk("t2_pkt_cnt0", pkt_cnt0, 1);
    chk("t2_pkt_cnt1", pkt_cnt1, 2);
    chk_seq("t2_out0_seq", 1'b0, 1, 32'h0000_00A5);
    chk_seq("t2_out1_seq", 1'b1, 2, 32'h0000_B2B1);
    clear_logs();

    // Stalled ch0: two beats fit, the third is refused until release.
    out0_ready = 1'b0;
    send(8'hC1, 1'b0, 1'b1, 1'b0);
    send(8'hC2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hC3; in_channel = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_in_ready", in_ready, 0);
    end
    chk("t3_stall_head", out0_data, 8'hC1);
    @(posedge clk);
    #1 out0_ready = 1'b1;
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'hC4, 1'b0, 1'b0, 1'b1);
    idle_cycles(4);
    chk_seq("t3_out0_seq", 1'b0, 4, 32'hC4C3_C2C1);
    chk("t3_pkt_cnt0", pkt_cnt0, 2);
    clear_logs();

    // out0 full and stalled; a ch1 packet still flows through.
    out0_ready = 1'b0;
    send(8'h41, 1'b0, 1'b1, 1'b0);
    send(8'h42, 1'b0, 1'b0, 1'b1);
    send(8'h51, 1'b1, 1'b1, 1'b0);
    send(8'h52, 1'b0, 1'b0, 1'b0);
    send(8'h53, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    chk("t4_out0_held", out0_valid, 1);
    chk("t4_out0_head", out0_data, 8'h41);
    chk_seq("t4_out1_seq", 1'b1, 3, 32'h0053_5251);
    out0_ready = 1'b1;
    idle_cycles(3);
    chk_seq("t4_out0_seq", 1'b0, 2, 32'h0000_4241);
    chk("t4_pkt_cnt0", pkt_cnt0, 3);
    chk("t4_pkt_cnt1", pkt_cnt1, 3);
    clear_logs();

    // sop mid-packet on ch0 with in_channel=1: truncate and re-route, then async reset.
    out1_ready = 1'b0;
    send(8'h01, 1'b0, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    chk("t5_no_err_yet", proto_err, 0);
    send(8'h03, 1'b1, 1'b1, 1'b0);
    chk("t5_proto_err", proto_err, 1);
    chk("t5_pkt_cnt0", pkt_cnt0, 3);
    chk("t5_out1_valid", out1_valid, 1);
    chk("t5_out1_data", out1_data, 8'h03);
    chk("t5_out1_sop", out1_sop, 1);
    chk_seq("t5_out0_seq", 1'b0, 2, 32'h0000_0201);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_out1_valid", out1_valid, 0);
    chk("t5_rst_out0_valid", out0_valid, 0);
    chk("t5_rst_pkt_cnt0", pkt_cnt0, 0);
    chk("t5_rst_pkt_cnt1", pkt_cnt1, 0);
    chk("t5_rst_proto_err", proto_err, 0);
    out1_ready = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Stray non-sop beat while idle: dropped.
    send(8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t6_drop_cnt", drop_cnt, 1);
    chk("t6_proto_err", proto_err, 1);
    idle_cycles(2);
    chk("t6_out0_valid", out0_valid, 0);
    chk("t6_out1_valid", out1_valid, 0);
    chk("t6_no_output", got0.size() + got1.size(), 0);

    // A clean packet after the drop still routes and counts normally.
    send(8'h77, 1'b0, 1'b1, 1'b1);
    idle_cycles(2);
    chk("t7_pkt_cnt0", pkt_cnt0, 1);
    chk_seq("t7_out0_seq", 1'b0, 1, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
